// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared datapath definitions for the program-counter unit.
//   - state_t      : run/halt/fault state encoding
//   - PC_SRC_*     : next-PC select codes driven on pc_src
//   - SYSCALL_INSN : the instruction word that halts the core
//   - DEF_*        : default text window base and reset PC
package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_JR     = 2'd3;

    localparam logic [31:0] SYSCALL_INSN  = 32'h0000000C;
    localparam logic [31:0] DEF_TEXT_BASE = 32'h00400000;
    localparam logic [31:0] DEF_RESET_PC  = 32'h00400000;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control bus between the pipeline and the PC unit.
//   master : drives stall, instr, pc_src, branch_taken, reg_target;
//            observes pc, pc_plus4, halted, fault, fault_pc, fetch_count
//   slave  : the PC unit side (directions reversed)
interface pc_unit_if;
    logic        stall;
    logic [31:0] instr;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    modport master (
        output stall, instr, pc_src, branch_taken, reg_target,
        input  pc, pc_plus4, halted, fault, fault_pc, fetch_count
    );

    modport slave (
        input  stall, instr, pc_src, branch_taken, reg_target,
        output pc, pc_plus4, halted, fault, fault_pc, fetch_count
    );
endinterface

// File: rtl/pc_unit_next_pc_logic.sv
// next_pc_logic: purely combinational next-PC selection and legality check.
//   pc, instr_lo (instr[25:0]), pc_src, branch_taken, reg_target -> inputs
//   pc_plus4 : pc + 4
//   next_pc  : selected candidate PC (all arithmetic wraps modulo 2^32)
//   legal    : word aligned and inside [TEXT_BASE, TEXT_BASE + 4*TEXT_WORDS)
module next_pc_logic
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
    parameter int          TEXT_WORDS = 256
) (
    input  logic [31:0] pc,
    input  logic [25:0] instr_lo,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        legal
);
    // Upper bound kept at 33 bits so a window ending exactly at 2^32 still
    // compares correctly.
    localparam logic [32:0] TEXT_LIMIT = {1'b0, TEXT_BASE} + (33'(TEXT_WORDS) << 2);

    logic [31:0] br_off;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{instr_lo[15]}}, instr_lo[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PC_SRC_SEQ:    next_pc = pc_plus4;
            PC_SRC_BRANCH: next_pc = branch_taken ? (pc_plus4 + br_off) : pc_plus4;
            PC_SRC_JUMP:   next_pc = {pc_plus4[31:28], instr_lo, 2'b00};
            PC_SRC_JR:     next_pc = reg_target;
            default:       next_pc = pc_plus4;
        endcase
    end

    assign legal = (next_pc[1:0] == 2'b00) &&
                   (next_pc >= TEXT_BASE) &&
                   ({1'b0, next_pc} < TEXT_LIMIT);
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with run/halt/fault control.
//   clock, clear : single clock, synchronous active-high clear
//   bus (slave)  : stall/instr/pc_src/branch_taken/reg_target in;
//                  pc, pc_plus4, halted, fault, fault_pc, fetch_count out
// The PC only moves in RUN without stall. A syscall halts, an illegal
// target faults (target captured in fault_pc); both are sticky until clear.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
    parameter int          TEXT_WORDS = 256
) (
    input  logic      clock,
    input  logic      clear,
    pc_unit_if.slave  bus
);
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] pc_plus4, next_pc;
    logic        legal;

    next_pc_logic #(
        .TEXT_BASE  (TEXT_BASE),
        .TEXT_WORDS (TEXT_WORDS)
    ) u_next_pc (
        .pc           (pc_q),
        .instr_lo     (bus.instr[25:0]),
        .pc_src       (bus.pc_src),
        .branch_taken (bus.branch_taken),
        .reg_target   (bus.reg_target),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .legal        (legal)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fpc_d   = fpc_q;
        if (state_q == ST_RUN && !bus.stall) begin
            // syscall is checked first so a halting instruction never faults
            if (bus.instr == SYSCALL_INSN) begin
                state_d = ST_HALT;
            end else if (!legal) begin
                state_d = ST_FAULT;
                fpc_d   = next_pc;
            end else begin
                pc_d  = next_pc;
                cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            fpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fpc_q   <= fpc_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.fault_pc    = fpc_q;
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit. Each driven cycle
// pushes the hand-computed post-edge state; a negedge monitor pops and
// compares against the DUT outputs.
module tb_pc_unit;
    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic        fault;
        logic [31:0] fault_pc;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    logic clock = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    pc_unit_if bus();

    pc_unit #(
        .RESET_PC   (32'h00400000),
        .TEXT_BASE  (32'h00400000),
        .TEXT_WORDS (256)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk32(input string nm, input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%08h required=%08h", tag, nm, act, req);
        end
    endtask

    // monitor: compare the state presented after each driven edge
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk32("pc",          e.tag, bus.pc,                 e.pc);
            chk32("pc_plus4",    e.tag, bus.pc_plus4,           e.pc + 32'd4);
            chk32("halted",      e.tag, {31'd0, bus.halted},    {31'd0, e.halted});
            chk32("fault",       e.tag, {31'd0, bus.fault},     {31'd0, e.fault});
            chk32("fault_pc",    e.tag, bus.fault_pc,           e.fault_pc);
            chk32("fetch_count", e.tag, bus.fetch_count,        e.cnt);
        end
    end

    // drive one cycle of inputs, then queue the expected post-edge state
    task automatic cyc(input string tag, input logic clr, input logic st,
                       input logic [31:0] ins, input logic [1:0] src, input logic bt,
                       input logic [31:0] rt, input logic [31:0] epc, input logic eh,
                       input logic ef, input logic [31:0] efpc, input logic [31:0] ecnt);
        exp_t e;
        clear            = clr;
        bus.stall        = st;
        bus.instr        = ins;
        bus.pc_src       = src;
        bus.branch_taken = bt;
        bus.reg_target   = rt;
        @(posedge clock);
        e.pc = epc; e.halted = eh; e.fault = ef; e.fault_pc = efpc; e.cnt = ecnt; e.tag = tag;
        sb.push_back(e);
        #1;
    endtask

    localparam logic [31:0] ADDI = 32'h20100001;
    localparam logic [31:0] SYSC = 32'h0000000C;
    localparam logic [31:0] BEQ  = 32'h1000FFFE;

    initial begin
        // reset and sequential advance
        cyc("reset",  1, 0, ADDI, 0, 0, 0, 32'h00400000, 0, 0, 0, 0);
        cyc("seq1",   0, 0, ADDI, 0, 0, 0, 32'h00400004, 0, 0, 0, 1);
        cyc("seq2",   0, 0, ADDI, 0, 0, 0, 32'h00400008, 0, 0, 0, 2);
        cyc("seq3",   0, 0, ADDI, 0, 0, 0, 32'h0040000C, 0, 0, 0, 3);
        // branch taken / not taken from 00400008
        cyc("clr_b",  1, 0, ADDI, 0, 0, 0, 32'h00400000, 0, 0, 0, 0);
        cyc("to4",    0, 0, ADDI, 0, 0, 0, 32'h00400004, 0, 0, 0, 1);
        cyc("to8",    0, 0, ADDI, 0, 0, 0, 32'h00400008, 0, 0, 0, 2);
        cyc("br_tk",  0, 0, BEQ,  1, 1, 0, 32'h00400004, 0, 0, 0, 3);
        cyc("to8b",   0, 0, ADDI, 0, 0, 0, 32'h00400008, 0, 0, 0, 4);
        cyc("br_nt",  0, 0, BEQ,  1, 0, 0, 32'h0040000C, 0, 0, 0, 5);
        // misaligned jr target faults; fault is sticky
        cyc("flt_mis",0, 0, ADDI, 3, 0, 32'h00400402, 32'h0040000C, 0, 1, 32'h00400402, 5);
        cyc("flt_hld",0, 0, ADDI, 0, 0, 0,            32'h0040000C, 0, 1, 32'h00400402, 5);
        // upper window edge: last word legal, one past faults
        cyc("clr_f",  1, 0, ADDI, 0, 0, 0, 32'h00400000, 0, 0, 0, 0);
        cyc("jr_top", 0, 0, ADDI, 3, 0, 32'h004003FC, 32'h004003FC, 0, 0, 0, 1);
        cyc("flt_top",0, 0, ADDI, 3, 0, 32'h00400400, 32'h004003FC, 0, 1, 32'h00400400, 1);
        // clear during fault with stall
        cyc("clr_stl",1, 1, ADDI, 3, 0, 32'h00400400, 32'h00400000, 0, 0, 0, 0);
        // jump and lower window edge
        cyc("jump",   0, 0, 32'h08100010, 2, 0, 0, 32'h00400040, 0, 0, 0, 1);
        cyc("flt_low",0, 0, ADDI, 3, 0, 32'h003FFFFC, 32'h00400040, 0, 1, 32'h003FFFFC, 1);
        // syscall wins over an illegal target, then holds for 5 cycles
        cyc("clr_h",  1, 0, ADDI, 0, 0, 0, 32'h00400000, 0, 0, 0, 0);
        cyc("halt",   0, 0, SYSC, 3, 0, 32'h00400402, 32'h00400000, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc("hhold", 0, 0, ADDI, 3, 0, 32'h00400402, 32'h00400000, 1, 0, 0, 0);
        // stall freezes a pending syscall; release halts
        cyc("clr_s",  1, 0, ADDI, 0, 0, 0, 32'h00400000, 0, 0, 0, 0);
        cyc("s_adv",  0, 0, ADDI, 0, 0, 0, 32'h00400004, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            cyc("stall", 0, 1, SYSC, 0, 0, 0, 32'h00400004, 0, 0, 0, 1);
        cyc("s_rel",  0, 0, SYSC, 0, 0, 0, 32'h00400004, 1, 0, 0, 1);
        cyc("clr_hs", 1, 1, SYSC, 0, 0, 0, 32'h00400000, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000, meaning the PC value loaded on clear.
REQ-002 SHALL have parameter TEXT_BASE, default 32'h00400000, meaning the lowest legal fetch address.
REQ-003 SHALL have parameter TEXT_WORDS, default 256, meaning the text window size in 32-bit words.
REQ-004 SHALL have port clock, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-005 SHALL have port clear, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1 bit: hold the PC and all state this cycle.
REQ-007 SHALL have port instr, input, 32 bits: the instruction currently fetched at pc.
REQ-008 SHALL have port pc_src, input, 2 bits: next-PC select (0 sequential, 1 branch, 2 jump, 3 jump-register).
REQ-009 SHALL have port branch_taken, input, 1 bit: the branch condition when pc_src=1.
REQ-010 SHALL have port reg_target, input, 32 bits: the register value used when pc_src=3.
REQ-011 SHALL have port pc, output, 32 bits: the current fetch address.
REQ-012 SHALL have port pc_plus4, output, 32 bits: pc+4, computed combinationally.
REQ-013 SHALL have port halted, output, 1 bit: high while in state HALT.
REQ-014 SHALL have port fault, output, 1 bit: high while in state FAULT.
REQ-015 SHALL have port fault_pc, output, 32 bits: the rejected next-PC value latched on entry to FAULT.
REQ-016 SHALL have port fetch_count, output, 32 bits: the number of PC advances since clear.

Function
REQ-017 SHALL implement states RUN, HALT and FAULT; the PC advances only in RUN with stall=0.
REQ-018 SHALL compute next-PC as follows: sel 0 gives pc_plus4; sel 1 gives pc_plus4 + (sign-extended instr[15:0] << 2) if branch_taken, else pc_plus4; sel 2 gives {pc_plus4[31:28], instr[25:0], 2'b00}; sel 3 gives reg_target.
REQ-019 SHALL perform all address arithmetic modulo 2^32, with no carry-out detection.
REQ-020 SHALL treat next-PC as legal iff bits[1:0]=0 and TEXT_BASE <= next-PC < TEXT_BASE + 4*TEXT_WORDS.
REQ-021 SHALL, in RUN with stall=0 and instr=32'h0000000C (syscall), enter HALT and leave pc unchanged.
REQ-022 SHALL, in RUN with stall=0, a non-syscall instruction and an illegal next-PC, enter FAULT, latch next-PC into fault_pc and leave pc unchanged.
REQ-023 SHALL, in RUN with stall=0, a non-syscall instruction and a legal next-PC, load pc with next-PC the following cycle (one-cycle latency).
REQ-024 SHALL give syscall detection priority over fault detection within the same cycle.
REQ-025 SHALL, when stall=1, ignore instr and pc_src, make no state transition, and leave the count unchanged.
REQ-026 SHALL increment fetch_count by 1 on each PC load and saturate it at 32'hFFFFFFFF.
REQ-027 SHALL exit HALT and FAULT only via clear, holding all outputs constant in the meantime.

Reset
REQ-028 SHALL, when clear=1 at a rising edge, set pc=RESET_PC, state=RUN, fetch_count=0, fault_pc=0, halted=0 and fault=0, regardless of stall.
REQ-029 SHALL give clear precedence over every other input, including when asserted in HALT, in FAULT, or mid-stall.

Structure
REQ-030 SHALL place the state encoding, the pc_src codes, the SYSCALL opcode constant and the default TEXT_BASE/RESET_PC values in a shared datapath package.
REQ-031 SHALL place the next-PC selection and legality check in one combinational sub-module, next_pc_logic; the state register, PC register and counter remain in pc_unit.

Verification
REQ-032 SHALL verify sequential advance: clear, then 3 cycles with pc_src=0 and instr=32'h20100001 -> pc 00400000, 00400004, 00400008, 0040000C and fetch_count=3.
REQ-033 SHALL verify branch: pc=00400008, pc_src=1, branch_taken=1, instr=32'h1000FFFE -> pc=00400004; with branch_taken=0 -> pc=0040000C.
REQ-034 SHALL verify fault: pc_src=3 and reg_target=32'h00400402 -> fault=1, fault_pc=00400402, pc unchanged; reg_target=32'h00400400 also faults.
REQ-035 SHALL verify halt priority: instr=32'h0000000C with pc_src=3 and illegal reg_target -> halted=1, fault=0, pc unchanged for 5 further cycles.
REQ-036 SHALL verify stall: stall=1 for 4 cycles with instr=32'h0000000C -> pc, fetch_count and state unchanged; releasing stall then halts.
REQ-037 SHALL verify reset mid-operation: clear during FAULT together with stall=1 -> next cycle pc=00400000, fault=0, fetch_count=0.
